// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32 opcodes, immediate-format codes (also used by imm_gen) and the canonical NOP.
package cpu_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] IMM_I   = 3'b000;
   localparam logic [2:0] IMM_ISH = 3'b001;
   localparam logic [2:0] IMM_S   = 3'b010;
   localparam logic [2:0] IMM_B   = 3'b011;
   localparam logic [2:0] IMM_U   = 3'b100;
   localparam logic [2:0] IMM_J   = 3'b101;

   localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/imm_sel_dec.sv
// Combinational opcode/funct3 -> immediate-format decoder.
// With ID_ILLEGAL_TRAP_EN defined it also flags opcodes outside the supported RV32I set.
module imm_sel_dec
   import cpu_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output logic [2:0] imm_sel,
`ifdef ID_ILLEGAL_TRAP_EN
   output logic       illegal,
`endif
   output logic       imm_used
);

   always_comb begin
      imm_sel  = IMM_I;
      imm_used = 1'b1;
      case (opcode)
         OP_LOAD, OP_JALR: imm_sel = IMM_I;
         OP_IMM:           imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_ISH : IMM_I;
         OP_STORE:         imm_sel = IMM_S;
         OP_BRANCH:        imm_sel = IMM_B;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         OP_JAL:           imm_sel = IMM_J;
         default:          imm_used = 1'b0;
      endcase
   end

`ifdef ID_ILLEGAL_TRAP_EN
   // Every legal opcode ends in 2'b11, so membership alone also covers the low-bit check.
   always_comb begin
      illegal = 1'b1;
      case (opcode)
         OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM: illegal = 1'b0;
         default:                                      illegal = 1'b1;
      endcase
   end
`endif

endmodule

// File: rtl/id_decode_buf.sv
// IF/ID 2-entry skid buffer with registered immediate-format decode feeding imm_gen.
// Optional macro ID_ILLEGAL_TRAP_EN adds the out_illegal output.
module id_decode_buf
   import cpu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic [2:0]      out_imm_sel,
`ifdef ID_ILLEGAL_TRAP_EN
   output logic            out_illegal,
`endif
   output logic            out_imm_used
);

   logic            accept;
   logic [2:0]      dec_imm_sel;
   logic            dec_imm_used;
   logic            skid_valid;
   logic [XLEN-1:0] skid_inst;
   logic [XLEN-1:0] skid_pc;
   logic [2:0]      skid_imm_sel;
   logic            skid_imm_used;
`ifdef ID_ILLEGAL_TRAP_EN
   logic            dec_illegal;
   logic            skid_illegal;
`endif

   assign accept = in_valid && in_ready;

   imm_sel_dec u_dec (
      .opcode   (in_inst[6:0]),
      .funct3   (in_inst[14:12]),
      .imm_sel  (dec_imm_sel),
`ifdef ID_ILLEGAL_TRAP_EN
      .illegal  (dec_illegal),
`endif
      .imm_used (dec_imm_used)
   );

   // in_ready tracks !skid_valid as a register, so out_ready never reaches it combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_inst      <= NOP_INST;
         out_pc        <= '0;
         out_imm_sel   <= IMM_I;
         out_imm_used  <= 1'b0;
         skid_valid    <= 1'b0;
         skid_inst     <= NOP_INST;
         skid_pc       <= '0;
         skid_imm_sel  <= IMM_I;
         skid_imm_used <= 1'b0;
         in_ready      <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
         out_illegal   <= 1'b0;
         skid_illegal  <= 1'b0;
`endif
      end else if (flush) begin
         out_valid    <= 1'b0;
         out_inst     <= NOP_INST;
         out_imm_sel  <= IMM_I;
         out_imm_used <= 1'b0;
         skid_valid   <= 1'b0;
         in_ready     <= 1'b1;
`ifdef ID_ILLEGAL_TRAP_EN
         out_illegal  <= 1'b0;
`endif
      end else if (!out_valid || out_ready) begin
         in_ready <= 1'b1;
         // The skid entry is older than anything on the input, so it always drains first.
         if (skid_valid) begin
            out_valid    <= 1'b1;
            out_inst     <= skid_inst;
            out_pc       <= skid_pc;
            out_imm_sel  <= skid_imm_sel;
            out_imm_used <= skid_imm_used;
            skid_valid   <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
            out_illegal  <= skid_illegal;
`endif
         end else if (accept) begin
            out_valid    <= 1'b1;
            out_inst     <= in_inst;
            out_pc       <= in_pc;
            out_imm_sel  <= dec_imm_sel;
            out_imm_used <= dec_imm_used;
`ifdef ID_ILLEGAL_TRAP_EN
            out_illegal  <= dec_illegal;
`endif
         end else begin
            out_valid    <= 1'b0;
            out_inst     <= NOP_INST;
            out_imm_sel  <= IMM_I;
            out_imm_used <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
            out_illegal  <= 1'b0;
`endif
         end
      end else if (accept) begin
         skid_valid    <= 1'b1;
         skid_inst     <= in_inst;
         skid_pc       <= in_pc;
         skid_imm_sel  <= dec_imm_sel;
         skid_imm_used <= dec_imm_used;
         in_ready      <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
         skid_illegal  <= dec_illegal;
`endif
      end
   end

endmodule

// File: tb/tb_id_decode_buf.sv
// Self-checking bench for id_decode_buf: a FIFO-level reference model checked every cycle plus directed literal checks.
module tb_id_decode_buf;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  out_imm_sel;
   logic        out_imm_used;
`ifdef ID_ILLEGAL_TRAP_EN
   logic        out_illegal;
`endif

   int errors = 0;
   int checks = 0;

   entry_t      model_q[$];
   logic        model_ready;
   logic [31:0] model_pc;
   logic [31:0] tbl [8];

   id_decode_buf dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_inst     (out_inst),
      .out_pc       (out_pc),
      .out_imm_sel  (out_imm_sel),
`ifdef ID_ILLEGAL_TRAP_EN
      .out_illegal  (out_illegal),
`endif
      .out_imm_used (out_imm_used)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate format straight from the opcode table: {imm_used, imm_sel}.
   function automatic logic [3:0] spec_imm(input logic [31:0] inst);
      logic [6:0] op;
      logic [2:0] f3;
      op = inst[6:0];
      f3 = inst[14:12];
      if (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) return 4'b1001;
      if (op == 7'b0000011 || op == 7'b1100111 || op == 7'b0010011) return 4'b1000;
      if (op == 7'b0100011) return 4'b1010;
      if (op == 7'b1100011) return 4'b1011;
      if (op == 7'b0110111 || op == 7'b0010111) return 4'b1100;
      if (op == 7'b1101111) return 4'b1101;
      return 4'b0000;
   endfunction

`ifdef ID_ILLEGAL_TRAP_EN
   function automatic logic spec_illegal(input logic [31:0] inst);
      logic [6:0] op;
      op = inst[6:0];
      if (op[1:0] != 2'b11) return 1'b1;
      return !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011});
   endfunction
`endif

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, then settle just after the next rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                input logic rdy, input logic fl);
      @(negedge clk);
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      #2;
   endtask

   // Reference model: the buffer is an ordered queue of at most two accepted instructions.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_q.delete();
         model_ready = 1'b0;
         model_pc    = '0;
      end else begin
         if (flush) begin
            model_q.delete();
         end else begin
            logic take;
            take = in_valid && model_ready;
            if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
            if (take) model_q.push_back('{inst: in_inst, pc: in_pc});
         end
         if (model_q.size() > 0) model_pc = model_q[0].pc;
         model_ready = (model_q.size() < 2);
         #1;
         begin
            logic [31:0] e_inst;
            logic [3:0]  e_imm;
            e_inst = (model_q.size() > 0) ? model_q[0].inst : 32'h00000013;
            e_imm  = (model_q.size() > 0) ? spec_imm(e_inst) : 4'b0000;
            checkOutput("cyc_out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
            checkOutput("cyc_out_inst", out_inst, e_inst);
            checkOutput("cyc_out_pc", out_pc, model_pc);
            checkOutput("cyc_imm_sel", {29'd0, out_imm_sel}, {29'd0, e_imm[2:0]});
            checkOutput("cyc_imm_used", {31'd0, out_imm_used}, {31'd0, e_imm[3]});
            checkOutput("cyc_in_ready", {31'd0, in_ready}, {31'd0, model_ready});
`ifdef ID_ILLEGAL_TRAP_EN
            checkOutput("cyc_illegal", {31'd0, out_illegal},
                        {31'd0, (model_q.size() > 0) && spec_illegal(e_inst)});
`endif
         end
      end
   end

   initial begin
      tbl = '{32'hFFB00093, 32'h00409093, 32'h00112E23, 32'h00000463,
              32'h123450B7, 32'hAAAAA0EF, 32'h002081B3, 32'h0040D013};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_inst", out_inst, 32'h00000013);
      checkOutput("rst_out_pc", out_pc, 32'd0);
      checkOutput("rst_imm", {28'd0, out_imm_used, out_imm_sel}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Single addi
      applyStimulus(1'b1, 32'hFFB00093, 32'h100, 1'b1, 1'b0);
      checkOutput("addi_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("addi_sel", {29'd0, out_imm_sel}, 32'd0);
      checkOutput("addi_used", {31'd0, out_imm_used}, 32'd1);
      checkOutput("addi_pc", out_pc, 32'h100);

      // Back-to-back formats, no bubbles
      applyStimulus(1'b1, 32'h00409093, 32'h104, 1'b1, 1'b0);
      checkOutput("slli_sel", {29'd0, out_imm_sel}, 32'd1);
      applyStimulus(1'b1, 32'h00112E23, 32'h108, 1'b1, 1'b0);
      checkOutput("sw_sel", {29'd0, out_imm_sel}, 32'd2);
      applyStimulus(1'b1, 32'h00000463, 32'h10C, 1'b1, 1'b0);
      checkOutput("beq_sel", {29'd0, out_imm_sel}, 32'd3);
      applyStimulus(1'b1, 32'h123450B7, 32'h110, 1'b1, 1'b0);
      checkOutput("lui_sel", {29'd0, out_imm_sel}, 32'd4);
      applyStimulus(1'b1, 32'hAAAAA0EF, 32'h114, 1'b1, 1'b0);
      checkOutput("jal_sel", {29'd0, out_imm_sel}, 32'd5);
      checkOutput("jal_valid", {31'd0, out_valid}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

      // Stall with A, B, C then release
      applyStimulus(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
      checkOutput("stall_a", out_inst, 32'h00100093);
      applyStimulus(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
      checkOutput("stall_a_held", out_inst, 32'h00100093);
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
      checkOutput("stall_c_blocked", out_inst, 32'h00100093);
      applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
      checkOutput("order_b", out_inst, 32'h00200113);
      checkOutput("order_b_pc", out_pc, 32'h204);
      checkOutput("order_in_ready", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
      checkOutput("order_c", out_inst, 32'h00300193);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("order_empty", {31'd0, out_valid}, 32'd0);

      // Flush with skid full, then flush while an input would be accepted
      applyStimulus(1'b1, 32'h00400213, 32'h300, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00500293, 32'h304, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00600313, 32'h308, 1'b0, 1'b1);
      checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_inst", out_inst, 32'h00000013);
      checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("flush_pc_held", out_pc, 32'h300);
      applyStimulus(1'b1, 32'h00700393, 32'h30C, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00800413, 32'h310, 1'b0, 1'b1);
      checkOutput("flush2_valid", {31'd0, out_valid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush2_gone", {31'd0, out_valid}, 32'd0);

      // No-immediate and illegal opcodes
      applyStimulus(1'b1, 32'h002081B3, 32'h400, 1'b1, 1'b0);
      checkOutput("add_sel", {29'd0, out_imm_sel}, 32'd0);
      checkOutput("add_used", {31'd0, out_imm_used}, 32'd0);
`ifdef ID_ILLEGAL_TRAP_EN
      applyStimulus(1'b1, 32'h0000007F, 32'h404, 1'b1, 1'b0);
      checkOutput("bad_illegal", {31'd0, out_illegal}, 32'd1);
      applyStimulus(1'b1, 32'h00000073, 32'h408, 1'b1, 1'b0);
      checkOutput("ecall_illegal", {31'd0, out_illegal}, 32'd0);
`endif

      // Mixed handshake pattern checked by the model
      for (int i = 0; i < 60; i++) begin
         applyStimulus(i % 4 != 1, tbl[i % 8], 32'h1000 + 32'(i * 4), i % 3 != 0, i == 37);
      end

      // Asynchronous reset between edges
      applyStimulus(1'b1, 32'h00900493, 32'h500, 1'b0, 1'b0);
      checkOutput("pre_arst_valid", {31'd0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("arst_inst", out_inst, 32'h00000013);
      checkOutput("arst_pc", out_pc, 32'd0);
      checkOutput("arst_imm", {28'd0, out_imm_used, out_imm_sel}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'h00A00513, 32'h600, 1'b1, 1'b0);
      checkOutput("post_arst_inst", out_inst, 32'h00A00513);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_decode_buf.md
Name: id_decode_buf

Overview:
- IF/ID boundary stage directly upstream of imm_gen.
- Accepts fetched instructions and PCs over a valid/ready handshake and buffers them in a 2-entry skid buffer (output register plus skid register).
- Decodes opcode/funct3 into the 3-bit imm_sel code; out_inst drives imm_gen.imm_in and out_imm_sel drives imm_gen.imm_sel.
- Provides stall (backpressure) and flush (branch/jump redirect) without dropping or duplicating instructions.

Parameters:
- XLEN, 32, width of instruction and PC.
- NOP_INST, 32'h00000013, value of out_inst while not valid and after reset/flush (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discard all buffered instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  buffer can accept; transfer occurs when in_valid && in_ready.
- in_inst  input  XLEN  fetched instruction.
- in_pc  input  XLEN  PC of in_inst.
- out_valid  output  1  out_* fields hold a valid instruction.
- out_ready  input  1  execute consumes; transfer occurs when out_valid && out_ready.
- out_inst  output  XLEN  instruction to imm_gen.imm_in.
- out_pc  output  XLEN  PC of out_inst.
- out_imm_sel  output  3  immediate format for imm_gen.imm_sel.
- out_imm_used  output  1  1 if the instruction carries an immediate.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_inst=NOP_INST, out_pc=0, out_imm_sel=3'b000, out_imm_used=0.
  - Skid entry invalid; in_ready=1 from the first clock after release.
- imm_sel encoding:
  - 000 I-type: opcode 0000011, 1100111, or 0010011 with funct3 not 001/101.
  - 001 I-shift: opcode 0010011 with funct3 001 or 101.
  - 010 S-type: opcode 0100011.
  - 011 B-type: opcode 1100011.
  - 100 U-type: opcode 0110111 or 0010111.
  - 101 J-type: opcode 1101111.
  - Any other opcode: 000 with imm_used=0. All listed opcodes give imm_used=1.
- Decode timing:
  - Decode is computed on in_inst at capture and stored with the entry.
  - out_imm_sel and out_imm_used are registered and never combinational from in_*.
- Latency: an accepted instruction appears on out_* the next cycle when the output register is empty or draining.
- Output register loading:
  - Output empty or out_ready=1: load from the skid entry if it is valid, otherwise from the input.
  - Output full and out_ready=0: an accepted input goes to the skid entry.
- in_ready:
  - Registered; equals !skid_valid. No combinational path from out_ready to in_ready.
  - Skid full and out_ready=1: output loads from skid, skid clears, in_ready=1 next cycle.
  - Skid full and out_ready=0: in_ready=0; in_* is ignored even if in_valid=1.
- Ordering: strictly FIFO; the skid entry always drains before any new input.
- Simultaneous accept and consume with skid empty: output register takes the new instruction; no bubble.
- Flush:
  - Next cycle: out_valid=0, skid invalid, out_inst=NOP_INST, in_ready=1.
  - Any input handshake in the flush cycle is discarded.
  - Flush has priority over all handshakes.
- Reset asserted mid-operation clears state immediately, independent of clk.
- While out_valid=0, out_pc is held at its last value.

Optional Feature:
- Macro: ID_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port out_illegal (1 bit), registered alongside the entry.
  - out_illegal=1 when opcode[1:0]!=2'b11 or opcode is not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 1110011}.
  - Reset and flush value 0.
- Not defined: port absent; illegal opcodes pass through with imm_used=0.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG, OP_SYSTEM).
  - IMM_I=3'b000, IMM_ISH=3'b001, IMM_S=3'b010, IMM_B=3'b011, IMM_U=3'b100, IMM_J=3'b101.
  - NOP constant.
- imm_gen uses the same IMM_* constants.
- One natural combinational sub-module: imm_sel_dec (inst -> imm_sel, imm_used, illegal), instantiated once on the input path.

Test Plan:
- Reset then in_inst=32'hFFB00093 (addi x1,x0,-5), pc=0x100, out_ready=1 -> next cycle out_valid=1, out_imm_sel=000, out_imm_used=1, out_pc=0x100.
- Back-to-back 0x00409093 (slli), 0x00112E23 (sw), 0x00000463 (beq), 0x123450B7 (lui), 0xAAAAA0EF (jal) with out_ready=1 -> imm_sel 001, 010, 011, 100, 101 on consecutive cycles with no bubbles.
- out_ready=0 while sending 3 instructions A, B, C -> A held on output, B in skid, in_ready=0 and C stalled. Then out_ready=1 -> output order A, B, C, nothing lost or duplicated.
- Skid full, assert flush with in_valid=1 -> next cycle out_valid=0, out_inst=0x00000013, in_ready=1; the flush-cycle input never appears.
- 0x002081B3 (add, R-type) -> imm_sel=000, imm_used=0. With ID_ILLEGAL_TRAP_EN, 0x0000007F -> out_illegal=1 and 0x00000073 -> out_illegal=0.
- Drop rst_n asynchronously between clock edges while out_valid=1 -> outputs reach reset values before the next clk edge.
